// File: rtl/wb_stage.sv
// Write-back stage: commits one register-file write per retired instruction.
// ALU results commit next cycle; loads wait for the dmem response or a timeout.
module wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_RegWrite,
    input  logic        mem_MemtoReg,
    input  logic [2:0]  mem_LoadType,
    input  logic [31:0] mem_ALUResult,
    input  logic [4:0]  mem_WriteReg,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        RegWrite,
    output logic        wb_stall,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [4:0]  ld_reg, ld_reg_n;
    logic        ld_we, ld_we_n;
    logic [2:0]  ld_type, ld_type_n;
    logic [1:0]  ld_addr, ld_addr_n;
    logic [4:0]  wreg_n;
    logic [31:0] wdata_n;
    logic        we_n, mis_n, to_n;
    logic        aligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign wb_stall = (state == WAIT);

    // Byte loads never fault; halfwords need even addresses, words (and reserved codes) need 4-byte alignment.
    always_comb begin
        aligned = 1'b0;
        case (mem_LoadType)
            3'b001, 3'b010: aligned = ~mem_ALUResult[0];
            3'b011, 3'b100: aligned = 1'b1;
            default:        aligned = (mem_ALUResult[1:0] == 2'b00);
        endcase
    end

    // Big-endian lane select: address offset 0 is the most significant byte of the word.
    always_comb begin
        ld_byte = 8'h00;
        case (ld_addr)
            2'd0: ld_byte = dmem_rdata[31:24];
            2'd1: ld_byte = dmem_rdata[23:16];
            2'd2: ld_byte = dmem_rdata[15:8];
            2'd3: ld_byte = dmem_rdata[7:0];
            default: ld_byte = 8'h00;
        endcase
        ld_half = ld_addr[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        ld_value = dmem_rdata;
        case (ld_type)
            3'b001: ld_value = {{16{ld_half[15]}}, ld_half};
            3'b010: ld_value = {16'h0000, ld_half};
            3'b011: ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_value = {24'h000000, ld_byte};
            default: ld_value = dmem_rdata;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ld_reg_n  = ld_reg;
        ld_we_n   = ld_we;
        ld_type_n = ld_type;
        ld_addr_n = ld_addr;
        wreg_n    = writeReg;
        wdata_n   = writeData;
        we_n      = 1'b0;
        mis_n     = 1'b0;
        to_n      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (!mem_MemtoReg) begin
                        wreg_n  = mem_WriteReg;
                        wdata_n = mem_ALUResult;
                        we_n    = mem_RegWrite && (mem_WriteReg != 5'd0);
                    end else if (aligned) begin
                        ld_reg_n  = mem_WriteReg;
                        ld_we_n   = mem_RegWrite;
                        ld_type_n = mem_LoadType;
                        ld_addr_n = mem_ALUResult[1:0];
                        cnt_n     = 8'd0;
                        state_n   = WAIT;
                    end else begin
                        mis_n = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A response on the final wait cycle still commits instead of timing out.
                if (dmem_rvalid) begin
                    wreg_n  = ld_reg;
                    wdata_n = ld_value;
                    we_n    = ld_we && (ld_reg != 5'd0);
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            ld_reg       <= 5'd0;
            ld_we        <= 1'b0;
            ld_type      <= 3'd0;
            ld_addr      <= 2'd0;
            writeReg     <= 5'd0;
            writeData    <= 32'd0;
            RegWrite     <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            ld_reg       <= ld_reg_n;
            ld_we        <= ld_we_n;
            ld_type      <= ld_type_n;
            ld_addr      <= ld_addr_n;
            writeReg     <= wreg_n;
            writeData    <= wdata_n;
            RegWrite     <= we_n;
            err_misalign <= mis_n;
            err_timeout  <= to_n;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a transaction-level model predicts each write/error
// event and its cycle; a negedge monitor pops and compares whatever the DUT presents.
module tb_wb_stage;

    localparam int TIMEOUT = 4;
    localparam int MAXC    = 16384;
    localparam int KW      = 0;
    localparam int KM      = 1;
    localparam int KT      = 2;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_RegWrite;
    logic        mem_MemtoReg;
    logic [2:0]  mem_LoadType;
    logic [31:0] mem_ALUResult;
    logic [4:0]  mem_WriteReg;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        RegWrite;
    logic        wb_stall;
    logic        err_misalign;
    logic        err_timeout;

    typedef struct {
        int          kind;
        int          cyc;
        logic [4:0]  wreg;
        logic [31:0] data;
    } ev_t;

    ev_t             expq[$];
    logic [31:0]     rv_sched[int];
    bit              exp_stall[MAXC];
    int              cyc = 0;
    int              free_edge = 0;
    int              checks = 0;
    int              errors = 0;
    bit              mon_en = 0;

    wb_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_LoadType(mem_LoadType), .mem_ALUResult(mem_ALUResult), .mem_WriteReg(mem_WriteReg),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite),
        .wb_stall(wb_stall), .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: presents a scheduled response for the coming edge, otherwise noise.
    always @(posedge clk) begin
        #2;
        if (rv_sched.exists(cyc + 1)) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rv_sched[cyc + 1];
        end else begin
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
        end
    end

    initial begin
        #(200000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int accessSize(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    // Reference extraction: plain shifts and masks, two's-complement sign handling by subtraction.
    function automatic logic [31:0] refLoad(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
        int          ofs;
        logic [31:0] b;
        logic [31:0] h;
        ofs = int'(a & 32'h3);
        b = (w >> (8 * (3 - ofs))) & 32'hFF;
        h = (w >> (16 * (1 - ofs / 2))) & 32'hFFFF;
        case (t)
            3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd2: return h;
            3'd3: return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4: return b;
            default: return w;
        endcase
    endfunction

    task automatic pushEvent(input int kind, input int c, input logic [4:0] r, input logic [31:0] d);
        ev_t ev;
        ev.kind = kind;
        ev.cyc  = c;
        ev.wreg = r;
        ev.data = d;
        expq.push_back(ev);
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        mem_valid     = 1'b0;
        mem_ALUResult = $urandom;
        mem_WriteReg  = 5'($urandom);
        repeat (n) stepEdge();
    endtask

    // Presents one instruction (held until captured) and predicts its outcome and timing.
    task automatic applyStimulus(input bit isLoad, input bit we, input logic [2:0] ltype,
                                 input logic [31:0] addr, input logic [4:0] wreg,
                                 input logic [31:0] rdata, input int lat);
        int e;
        int done;
        e = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
        mem_valid     = 1'b1;
        mem_RegWrite  = we;
        mem_MemtoReg  = isLoad;
        mem_LoadType  = ltype;
        mem_ALUResult = addr;
        mem_WriteReg  = wreg;
        if (isLoad && !rv_sched.exists(e)) rv_sched[e] = $urandom;
        while (cyc < e) stepEdge();
        if (!isLoad) begin
            if (we && wreg != 5'd0) pushEvent(KW, e, wreg, addr);
            free_edge = e + 1;
        end else if ((addr % accessSize(ltype)) != 0) begin
            pushEvent(KM, e, 5'd0, 32'd0);
            free_edge = e + 1;
        end else begin
            if (lat <= TIMEOUT) begin
                done = e + lat;
                rv_sched[done] = rdata;
                if (we && wreg != 5'd0) pushEvent(KW, done, wreg, refLoad(ltype, addr, rdata));
            end else begin
                done = e + TIMEOUT;
                pushEvent(KT, done, 5'd0, 32'd0);
                if (!rv_sched.exists(done + 1)) rv_sched[done + 1] = rdata;
            end
            for (int c = e; c < done; c++) if (c < MAXC) exp_stall[c] = 1'b1;
            free_edge = done + 1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            int  kind;
            ev_t ev;
            checkOutput("wb_stall", {31'd0, wb_stall}, (cyc < MAXC) ? {31'd0, exp_stall[cyc]} : 32'd0);
            if (RegWrite === 1'b1 || err_misalign === 1'b1 || err_timeout === 1'b1) begin
                kind = (RegWrite === 1'b1) ? KW : (err_misalign === 1'b1) ? KM : KT;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, required no event", kind, cyc);
                end else begin
                    ev = expq.pop_front();
                    checkOutput("event_kind", kind, ev.kind);
                    checkOutput("event_cycle", cyc, ev.cyc);
                    if (ev.kind == KW) begin
                        checkOutput("writeReg", {27'd0, writeReg}, {27'd0, ev.wreg});
                        checkOutput("writeData", writeData, ev.data);
                    end
                end
            end
        end
    end

    initial begin
        int e;
        rst           = 1'b0;
        mem_valid     = 1'b0;
        mem_RegWrite  = 1'b0;
        mem_MemtoReg  = 1'b0;
        mem_LoadType  = 3'd0;
        mem_ALUResult = 32'd0;
        mem_WriteReg  = 5'd0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = 32'd0;
        repeat (3) stepEdge();
        checkOutput("reset_writeReg", {27'd0, writeReg}, 32'd0);
        checkOutput("reset_writeData", writeData, 32'd0);
        checkOutput("reset_RegWrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("reset_wb_stall", {31'd0, wb_stall}, 32'd0);
        checkOutput("reset_err_misalign", {31'd0, err_misalign}, 32'd0);
        checkOutput("reset_err_timeout", {31'd0, err_timeout}, 32'd0);
        rst    = 1'b1;
        mon_en = 1'b1;

        applyStimulus(1'b0, 1'b1, 3'd0, 32'h0000_1234, 5'd5, 32'd0, 1);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'h0000_1234, 5'd0, 32'd0, 1);
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 3'd3, 32'h0000_1001, 5'd8,  32'h8081_F2F3, 3);
        applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_1001, 5'd9,  32'h8081_F2F3, 3);
        applyStimulus(1'b1, 1'b1, 3'd1, 32'h0000_1002, 5'd10, 32'h8081_F2F3, 3);
        applyStimulus(1'b1, 1'b1, 3'd2, 32'h0000_1002, 5'd11, 32'h8081_F2F3, 3);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_0100, 5'd12, 32'hCAFE_F00D, 2);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'h0000_0055, 5'd13, 32'd0, 1);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_0102, 5'd14, 32'h1111_2222, 2);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_0200, 5'd15, 32'h0000_0001, TIMEOUT + 2);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_0204, 5'd16, 32'h1234_5678, TIMEOUT);
        idleCycles(3);

        for (int i = 0; i < 250; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                          $urandom, 5'($urandom), $urandom, $urandom_range(1, TIMEOUT + 2));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end
        idleCycles(1);
        while (cyc < free_edge + 2) stepEdge();
        checkOutput("scoreboard_drained", expq.size(), 32'd0);

        // Reset arriving mid-load: the pending response must be discarded.
        e = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
        mem_valid = 1'b1; mem_RegWrite = 1'b1; mem_MemtoReg = 1'b1;
        mem_LoadType = 3'd0; mem_ALUResult = 32'h0000_0300; mem_WriteReg = 5'd7;
        while (cyc < e) stepEdge();
        mon_en    = 1'b0;
        mem_valid = 1'b0;
        rv_sched[e + 3] = 32'hDEAD_BEEF;
        stepEdge();
        checkOutput("stall_before_reset", {31'd0, wb_stall}, 32'd1);
        rst = 1'b0;
        stepEdge();
        rst = 1'b1;
        checkOutput("rst_wait_writeReg", {27'd0, writeReg}, 32'd0);
        checkOutput("rst_wait_writeData", writeData, 32'd0);
        checkOutput("rst_wait_RegWrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("rst_wait_wb_stall", {31'd0, wb_stall}, 32'd0);
        checkOutput("rst_wait_err_timeout", {31'd0, err_timeout}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            stepEdge();
            checkOutput("late_rvalid_RegWrite", {31'd0, RegWrite}, 32'd0);
            checkOutput("late_rvalid_wb_stall", {31'd0, wb_stall}, 32'd0);
            checkOutput("late_rvalid_writeData", writeData, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
